// File: rtl/muldiv_stall_unit.sv
// Iterative 16-cycle multiply/divide unit for the EX stage.
// Holds the pipeline via stop while busy and pulses done with the result.
module muldiv_stall_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_E,
    input  logic [1:0]            op_E,
    input  logic [DATA_WIDTH-1:0] a_E,
    input  logic [DATA_WIDTH-1:0] b_E,
    input  logic                  kill,
    output logic                  stop,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result_lo,
    output logic [DATA_WIDTH-1:0] result_hi
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MULS = 2'b01;
    localparam logic [1:0] OP_RSVD = 2'b11;

    // The destination index travels in the pipeline registers, not here.
    if (REG_WIDTH < 1) begin : g_bad_reg_width
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      op_q;
    logic            sign_q;
    logic [W-1:0]    opb_q;
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;
    logic [W-1:0]    res_lo_q;
    logic [W-1:0]    res_hi_q;

    logic            valid_start;
    logic            last;
    logic [W:0]      mul_sum;
    logic [W:0]      div_sh;
    logic            div_ge;
    logic [W-1:0]    div_df;
    logic [W-1:0]    hi_n;
    logic [W-1:0]    lo_n;
    logic [2*W-1:0]  prod;
    logic [2*W-1:0]  fin;
    logic [W-1:0]    a_abs;
    logic [W-1:0]    b_abs;

    assign valid_start = start_E && (op_E != OP_RSVD);
    assign last        = (cnt_q == CW'(DATA_WIDTH - 1));
    assign a_abs       = a_E[W-1] ? -a_E : a_E;
    assign b_abs       = b_E[W-1] ? -b_E : b_E;

    // hi/lo double as {acc_hi, multiplier} for MUL and {rem, dividend} for DIV.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_sh  = {hi_q, lo_q[W-1]};
        div_ge  = (div_sh >= {1'b0, opb_q});
        div_df  = div_sh[W-1:0] - opb_q;
        hi_n    = mul_sum[W:1];
        lo_n    = {mul_sum[0], lo_q[W-1:1]};
        if (op_q[1]) begin
            hi_n = div_ge ? div_df : div_sh[W-1:0];
            lo_n = {lo_q[W-2:0], div_ge};
        end
        prod = {hi_n, lo_n};
        fin  = prod;
        if (op_q == OP_MULS && sign_q) begin
            fin = -prod;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!kill && valid_start) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (kill) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign stop = !kill &&
                  ((state_q == IDLE && valid_start) || state_q == CALC);
    assign done = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MULU;
            sign_q   <= 1'b0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CALC && state_d == CALC) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
            if (state_q == IDLE && state_d == CALC) begin
                op_q <= op_E;
                hi_q <= '0;
                if (op_E == OP_MULS) begin
                    lo_q   <= a_abs;
                    opb_q  <= b_abs;
                    sign_q <= a_E[W-1] ^ b_E[W-1];
                end else begin
                    lo_q   <= a_E;
                    opb_q  <= b_E;
                    sign_q <= 1'b0;
                end
            end
            if (state_q == CALC && !kill) begin
                hi_q <= hi_n;
                lo_q <= lo_n;
                if (last) begin
                    res_lo_q <= fin[W-1:0];
                    res_hi_q <= fin[2*W-1:W];
                end
            end
        end
    end

    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;

endmodule

// File: tb/tb_muldiv_stall_unit.sv
// Scoreboard bench for muldiv_stall_unit.
// Directed ops push expectations; a monitor checks each done pulse.
module tb_muldiv_stall_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_E = 1'b0;
    logic [1:0]  op_E = 2'b00;
    logic [15:0] a_E = '0;
    logic [15:0] b_E = '0;
    logic        kill = 1'b0;
    logic        stop;
    logic        done;
    logic [15:0] result_lo;
    logic [15:0] result_hi;

    muldiv_stall_unit #(
        .DATA_WIDTH(16),
        .REG_WIDTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_E  (start_E),
        .op_E     (op_E),
        .a_E      (a_E),
        .b_E      (b_E),
        .kill     (kill),
        .stop     (stop),
        .done     (done),
        .result_lo(result_lo),
        .result_hi(result_hi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   stop_run = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            stop_run = 0;
        end else if (stop) begin
            stop_run++;
        end else begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", {31'd0, done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_hi"}, {16'd0, result_hi}, {16'd0, e.hi});
                    check({e.name, "_lo"}, {16'd0, result_lo}, {16'd0, e.lo});
                    check({e.name, "_stall"}, stop_run, e.lat);
                end
            end
            stop_run = 0;
        end
    end

    task automatic drive(input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] hi,
                         input logic [15:0] lo, input string name);
        start_E = 1'b1;
        op_E    = op;
        a_E     = a;
        b_E     = b;
        sb.push_back('{hi: hi, lo: lo, lat: 17, name: name});
        @(negedge clk);
        check({name, "_stop_at_start"}, {31'd0, stop}, 32'd1);
        check({name, "_done_at_start"}, {31'd0, done}, 32'd0);
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no done expected done", name);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] hi,
                         input logic [15:0] lo, input string name);
        @(posedge clk);
        #1;
        drive(op, a, b, hi, lo, name);
        wait_done(name);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        start_E = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stop", {31'd0, stop}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_res", {result_hi, result_lo}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, "mulu_ffff");
        check("mulu_stop_in_done", {31'd0, stop}, 32'd0);
        idle();
        issue(2'b00, 16'h1234, 16'h0010, 16'h0001, 16'h2340, "mulu_1234");
        idle();
        @(negedge clk);
        check("hold_after_done", {result_hi, result_lo}, 32'h0001_2340);
        check("done_pulse", {31'd0, done}, 32'd0);

        issue(2'b01, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, "muls_m3x5");
        idle();
        issue(2'b01, 16'h8000, 16'h8000, 16'h4000, 16'h0000, "muls_min");
        idle();
        issue(2'b01, 16'h0003, 16'hFFFE, 16'hFFFF, 16'hFFFA, "muls_3xm2");
        idle();

        issue(2'b10, 16'd100, 16'd7, 16'd2, 16'd14, "divu_100_7");
        idle();
        issue(2'b10, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, "divu_by0");
        idle();
        issue(2'b10, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, "divu_ffff_1");
        idle();

        issue(2'b10, 16'h00FF, 16'h0010, 16'h000F, 16'h000F, "b2b_first");
        issue(2'b10, 16'd9, 16'd3, 16'd0, 16'd3, "b2b_second");
        idle();

        @(posedge clk);
        #1;
        start_E = 1'b1;
        op_E    = 2'b00;
        a_E     = 16'hFFFF;
        b_E     = 16'hFFFF;
        repeat (6) @(posedge clk);
        #1;
        rst     = 1'b1;
        start_E = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_stop", {31'd0, stop}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_res", {result_hi, result_lo}, 32'd0);

        @(posedge clk);
        #1;
        start_E = 1'b1;
        op_E    = 2'b00;
        a_E     = 16'hABCD;
        b_E     = 16'h1234;
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(negedge clk);
        check("kill_stop", {31'd0, stop}, 32'd0);
        check("kill_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        kill = 1'b0;
        drive(2'b00, 16'd3, 16'd4, 16'd0, 16'd12, "after_kill");
        wait_done("after_kill");
        idle();

        @(posedge clk);
        #1;
        start_E = 1'b1;
        op_E    = 2'b11;
        a_E     = 16'd5;
        b_E     = 16'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rsvd_stop", {31'd0, stop}, 32'd0);
            check("rsvd_done", {31'd0, done}, 32'd0);
        end
        issue(2'b00, 16'h0002, 16'h8000, 16'h0001, 16'h0000, "after_rsvd");
        idle();

        repeat (3) @(posedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
